// File: rtl/cpu_pkg.sv
// Shared hazard-unit types: stage numbering, destination tag layout, select width helper.
package cpu_pkg;

  localparam int unsigned STG_EXE = 1;
  localparam int unsigned STG_MEM = 2;
  localparam int unsigned STG_WB  = 3;

  // Wide enough for a ready stage up to the maximum of 7 forwarding stages.
  localparam int unsigned RDY_W = 3;

  typedef struct packed {
    logic             v;
    logic [4:0]       addr;
    logic [RDY_W-1:0] rdy;
  } hz_tag_t;

  function automatic int unsigned sel_w(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_pick.sv
// Priority match of one source operand against the destination tag pipe.
module fwd_pick
  import cpu_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned SELW   = 2
) (
  input  logic            use_en,
  input  logic [4:0]      addr,
  input  hz_tag_t         tags [1:NSTAGE],
  output logic [SELW-1:0] sel,
  output logic            hazard
);

  logic found;

  // Lowest stage index is the youngest producer, so the first hit wins.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NSTAGE; k++) begin
      if (!found && use_en && (addr != 5'd0) && tags[k].v && (tags[k].addr == addr)) begin
        found = 1'b1;
        if (k >= 32'(tags[k].rdy)) begin
          sel = SELW'(k);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding/interlock controller: destination tag shadow pipe, HI/LO multiplier interlock, stall.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter  int unsigned NSTAGE   = 3,
  parameter  int unsigned LOAD_STG = 2,
  parameter  int unsigned CP0_STG  = 3,
  parameter  int unsigned MUL_LAT  = 4,
  localparam int unsigned SELW     = sel_w(NSTAGE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rsc,
  input  logic [4:0]      id_rtc,
  input  logic            id_rs_use,
  input  logic            id_rt_use,
  input  logic            id_wr_en,
  input  logic [4:0]      id_rdc,
  input  logic            id_is_load,
  input  logic            id_is_mfc0,
  input  logic            id_mul_start,
  input  logic            id_hilo_use,
  input  logic            flush,
  output logic [SELW-1:0] rs_fwd_sel,
  output logic [SELW-1:0] rt_fwd_sel,
  output logic            stall,
  output logic            mul_busy
);

  localparam int unsigned CNTW = $clog2(MUL_LAT + 1);

  hz_tag_t         tags [1:NSTAGE];
  hz_tag_t         id_tag;
  logic [CNTW-1:0] mul_cnt;
  logic            rs_haz;
  logic            rt_haz;
  logic            hilo_haz;
  logic            mul_accept;

  always_comb begin
    id_tag      = '0;
    id_tag.v    = id_valid & id_wr_en & (id_rdc != 5'd0);
    id_tag.addr = id_rdc;
    if (id_is_load) begin
      id_tag.rdy = RDY_W'(LOAD_STG);
    end else if (id_is_mfc0) begin
      id_tag.rdy = RDY_W'(CP0_STG);
    end else begin
      id_tag.rdy = RDY_W'(1);
    end
  end

  fwd_pick #(.NSTAGE(NSTAGE), .SELW(SELW)) u_rs_pick (
    .use_en (id_valid & id_rs_use),
    .addr   (id_rsc),
    .tags   (tags),
    .sel    (rs_fwd_sel),
    .hazard (rs_haz)
  );

  fwd_pick #(.NSTAGE(NSTAGE), .SELW(SELW)) u_rt_pick (
    .use_en (id_valid & id_rt_use),
    .addr   (id_rtc),
    .tags   (tags),
    .sel    (rt_fwd_sel),
    .hazard (rt_haz)
  );

  assign mul_busy   = (mul_cnt != '0);
  assign hilo_haz   = mul_busy & (id_hilo_use | id_mul_start);
  assign stall      = id_valid & ~flush & (rs_haz | rt_haz | hilo_haz);
  assign mul_accept = id_valid & id_mul_start & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= NSTAGE; k++) tags[k] <= '0;
      mul_cnt <= '0;
    end else if (flush) begin
      for (int unsigned k = 1; k <= NSTAGE; k++) tags[k] <= '0;
      mul_cnt <= '0;
    end else begin
      for (int unsigned k = NSTAGE; k >= 2; k--) tags[k] <= tags[k-1];
      tags[1] <= stall ? hz_tag_t'('0) : id_tag;
      if (mul_accept) begin
        mul_cnt <= CNTW'(MUL_LAT);
      end else if (mul_busy) begin
        mul_cnt <= mul_cnt - CNTW'(1);
      end
    end
  end

endmodule
